tempo_ramp_ctrl: RTL and testbench

TEMPO_RAMP_CTRL -- requirements
Module: tempo_ramp_ctrl

---
 rtl/tempo_ramp_ctrl_if.sv | 9 +
 rtl/tempo_ramp_ctrl.sv | 122 ++++++++++++
 tb/tb_tempo_ramp_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tempo_ramp_ctrl_if.sv
// tempo_ramp_ctrl_if: target-tempo valid/ready handshake between a requester and tempo_ramp_ctrl.
interface tempo_ramp_ctrl_if;
    logic [7:0] tgt_idx;
    logic       tgt_valid;
    logic       tgt_ready;

    modport master (output tgt_idx, output tgt_valid, input tgt_ready);
    modport slave  (input tgt_idx, input tgt_valid, output tgt_ready);
endinterface

// File: rtl/tempo_ramp_ctrl.sv
// tempo_ramp_ctrl: ramps the tempo index one step per STEP_CYCLES toward an accepted target.
// Optional beat output (wclk synchronizer + 256-edge divider) is built only when TEMPO_BEAT_OUT_EN is defined.
module tempo_ramp_ctrl #(
    parameter int STEP_CYCLES = 5_000_000,
    parameter int MAX_IDX     = 154,
    parameter int INIT_IDX    = 18
) (
    input  logic              clk,
    input  logic              reset,
    tempo_ramp_ctrl_if.slave  tgt,
    input  logic              hold,
    input  logic              wclk,
    output logic [7:0]        freq,
    output logic              ramping,
    output logic              done
`ifdef TEMPO_BEAT_OUT_EN
    ,
    output logic              beat
`endif
);
    // A single-cycle step period still needs a 1-bit counter to exist.
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);
    localparam logic [7:0]    MAX8 = 8'(MAX_IDX);
    localparam logic [7:0]    INIT8 = 8'(INIT_IDX);

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    freq_q, freq_d;
    logic [7:0]    target_q;
    logic [7:0]    clamp;
    logic          ready_q, ramping_q, done_q;
    logic          accept, step;

    assign freq          = freq_q;
    assign ramping       = ramping_q;
    assign done          = done_q;
    assign tgt.tgt_ready = ready_q;

    // Step timing: counter advances only while ramping and not held; terminal count moves freq one index toward target.
    always_comb begin
        clamp  = (tgt.tgt_idx > MAX8) ? MAX8 : tgt.tgt_idx;
        accept = (state_q == IDLE) && tgt.tgt_valid;
        step   = (state_q == RAMP) && !hold && (cnt_q == TERM);
        cnt_d  = accept ? '0 :
                 ((state_q == RAMP) && !hold) ? (step ? '0 : cnt_q + 1'b1) : cnt_q;
        freq_d = !step ? freq_q :
                 (target_q > freq_q) ? freq_q + 8'd1 : freq_q - 8'd1;
    end

    // Control FSM with registered handshake/status outputs; reset abandons any ramp in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            freq_q    <= INIT8;
            target_q  <= INIT8;
            ready_q   <= 1'b1;
            ramping_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            freq_q <= freq_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    target_q  <= clamp;
                    ready_q   <= 1'b0;
                    if (clamp == freq_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= RAMP;
                        ramping_q <= 1'b1;
                    end
                end
                RAMP: if (step && (freq_d == target_q)) begin
                    state_q   <= DONE;
                    ramping_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    ready_q   <= 1'b1;
                    ramping_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef TEMPO_BEAT_OUT_EN
    logic [2:0] ws_q;
    logic [7:0] bcnt_q;
    logic       beat_q;
    logic       wedge;

    assign wedge = ws_q[1] & ~ws_q[2];
    assign beat  = beat_q;

    // wclk crosses in through two flops; the third flop gives the rising-edge detect; a freq change restarts the beat phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_q   <= '0;
            bcnt_q <= '0;
            beat_q <= 1'b0;
        end else begin
            ws_q   <= {ws_q[1:0], wclk};
            bcnt_q <= (freq_d != freq_q) ? 8'd0 : wedge ? bcnt_q + 8'd1 : bcnt_q;
            beat_q <= (freq_d == freq_q) && wedge && (bcnt_q == 8'hFF);
        end
    end
`else
    logic unused_wclk;
    assign unused_wclk = wclk;
`endif
endmodule

// File: tb/tb_tempo_ramp_ctrl.sv
// tb_tempo_ramp_ctrl: directed self-checking bench for tempo_ramp_ctrl with STEP_CYCLES=4.
module tb_tempo_ramp_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic       wclk = 1'b0;
    logic [7:0] freq;
    logic       ramping, done;
    int         errors = 0;
    int         checks = 0;
    int         n;

    tempo_ramp_ctrl_if tif();

`ifdef TEMPO_BEAT_OUT_EN
    logic beat;
    logic prev_beat = 1'b0;
    int   beats = 0;
    int   wide = 0;
`endif

    tempo_ramp_ctrl #(.STEP_CYCLES(4), .MAX_IDX(154), .INIT_IDX(18)) dut (
        .clk     (clk),
        .reset   (reset),
        .tgt     (tif.slave),
        .hold    (hold),
        .wclk    (wclk),
        .freq    (freq),
        .ramping (ramping),
        .done    (done)
`ifdef TEMPO_BEAT_OUT_EN
        ,
        .beat    (beat)
`endif
    );

    always #5 clk = ~clk;

`ifdef TEMPO_BEAT_OUT_EN
    // Count beat pulses and flag any pulse lasting more than one clk.
    always @(negedge clk) begin
        if (beat === 1'b1) begin
            beats++;
            if (prev_beat) wide++;
        end
        prev_beat = beat;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] idx);
        tif.tgt_idx   = idx;
        tif.tgt_valid = 1'b1;
        @(negedge clk);
        tif.tgt_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int limit, output int nout);
        int k;
        k = start;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
            tif.tgt_valid = 1'b0;
        end
        nout = k;
    endtask

    initial begin
        tif.tgt_idx   = 8'd0;
        tif.tgt_valid = 1'b0;
        ticks(2);
        chk("rst_freq", freq, 18);
        chk("rst_ready", tif.tgt_ready, 1);
        chk("rst_ramping", ramping, 0);
        chk("rst_done", done, 0);
`ifdef TEMPO_BEAT_OUT_EN
        chk("rst_beat", beat, 0);
`endif
        reset = 1'b0;
        ticks(1);
        chk("post_rst_freq", freq, 18);
        chk("post_rst_ready", tif.tgt_ready, 1);

        send(8'd18);
        chk("eq_done", done, 1);
        chk("eq_ramping", ramping, 0);
        chk("eq_ready", tif.tgt_ready, 0);
        ticks(1);
        chk("eq_done_clr", done, 0);
        chk("eq_ready_back", tif.tgt_ready, 1);
        chk("eq_freq", freq, 18);

        send(8'd21);
        chk("r1_ramping", ramping, 1);
        chk("r1_ready", tif.tgt_ready, 0);
        chk("r1_freq0", freq, 18);
        ticks(3);
        chk("r1_freq_c3", freq, 18);
        ticks(1);
        chk("r1_freq19", freq, 19);
        ticks(3);
        chk("r1_freq_c7", freq, 19);
        ticks(1);
        chk("r1_freq20", freq, 20);
        ticks(3);
        chk("r1_freq_c11", freq, 20);
        chk("r1_done_early", done, 0);
        ticks(1);
        chk("r1_freq21", freq, 21);
        chk("r1_done", done, 1);
        chk("r1_ramping_off", ramping, 0);
        ticks(1);
        chk("r1_done_clr", done, 0);
        chk("r1_ready_back", tif.tgt_ready, 1);

        send(8'd200);
        wait_done(0, 2000, n);
        chk("clamp_time", n, 532);
        chk("clamp_freq", freq, 154);
        ticks(3);
        chk("clamp_hold_freq", freq, 154);
        chk("clamp_ramping", ramping, 0);

        hold = 1'b1;
        send(8'd154);
        chk("eqh_done", done, 1);
        ticks(1);
        chk("eqh_done_clr", done, 0);
        chk("eqh_ready", tif.tgt_ready, 1);
        hold = 1'b0;

        reset = 1'b1;
        #1;
        chk("rst2_freq", freq, 18);
        ticks(1);
        reset = 1'b0;
        ticks(1);

        send(8'd10);
        ticks(5);
        chk("h_freq17", freq, 17);
        hold = 1'b1;
        tif.tgt_idx   = 8'd50;
        tif.tgt_valid = 1'b1;
        ticks(1);
        tif.tgt_valid = 1'b0;
        ticks(9);
        chk("h_frozen", freq, 17);
        chk("h_ramping", ramping, 1);
        hold = 1'b0;
        tif.tgt_idx   = 8'd50;
        tif.tgt_valid = 1'b1;
        wait_done(15, 200, n);
        chk("h_time", n, 42);
        chk("h_freq10", freq, 10);
        ticks(5);
        chk("h_ignored_freq", freq, 10);
        chk("h_ignored_ramp", ramping, 0);

        send(8'd25);
        ticks(20);
        chk("mr_freq15", freq, 15);
        chk("mr_ramping", ramping, 1);
        reset = 1'b1;
        #1;
        chk("mr_rst_freq", freq, 18);
        chk("mr_rst_ramping", ramping, 0);
        chk("mr_rst_ready", tif.tgt_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) n++;
        end
        chk("mr_no_done", n, 0);
        chk("mr_freq_after", freq, 18);

`ifdef TEMPO_BEAT_OUT_EN
        repeat (512) begin
            #17 wclk = 1'b1;
            #17 wclk = 1'b0;
        end
        ticks(6);
        chk("beat_count", beats, 2);
        chk("beat_width", wide, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
